// File: rtl/trail_pkg.sv
// rtl/trail_pkg.sv - shared state encoding, grid defaults and address helpers for the trail engine
package trail_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        READ,
        WRITE,
        DONE
    } state_t;

    localparam int DEF_GRID_W = 200;
    localparam int DEF_GRID_H = 150;

    function automatic int owner_width(input int num_players);
        return $clog2(num_players + 1);
    endfunction

    function automatic logic [31:0] cell_addr(input logic [31:0] x, input logic [31:0] y,
                                              input logic [31:0] gw);
        return y * gw + x;
    endfunction

endpackage

// File: rtl/trail_ram.sv
// rtl/trail_ram.sv - simple dual-port grid RAM: engine read/write port plus display read port
module trail_ram #(
    parameter int DEPTH = 30000,
    parameter int AW    = 15,
    parameter int DW    = 2
) (
    input  logic          clock,
    input  logic          i_a_en,
    input  logic          i_a_we,
    input  logic [AW-1:0] i_a_addr,
    input  logic [DW-1:0] i_a_wdata,
    output logic [DW-1:0] o_a_rdata,
    input  logic [AW-1:0] i_b_addr,
    output logic [DW-1:0] o_b_rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    // Read-before-write on both ports: a same-cycle write is seen on the next access.
    always_ff @(posedge clock) begin
        if (i_a_en) begin
            if (i_a_we) begin
                r_mem[i_a_addr] <= i_a_wdata;
            end
            o_a_rdata <= r_mem[i_a_addr];
        end
        o_b_rdata <= r_mem[i_b_addr];
    end

endmodule

// File: rtl/trail_engine.sv
// rtl/trail_engine.sv - sequential N-player light-cycle collision checker and trail grid owner
module trail_engine
    import trail_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int GRID_W      = DEF_GRID_W,
    parameter int GRID_H      = DEF_GRID_H,
    parameter int COORD_W     = 10
) (
    input  logic                                  clock,
    input  logic                                  reset_n,
    input  logic                                  clear_req,
    input  logic                                  start,
    input  logic [NUM_PLAYERS*COORD_W-1:0]        head_x,
    input  logic [NUM_PLAYERS*COORD_W-1:0]        head_y,
    output logic                                  ready,
    output logic                                  done,
    output logic [NUM_PLAYERS-1:0]                alive,
    output logic [NUM_PLAYERS-1:0]                crashed,
    input  logic [COORD_W-1:0]                    disp_x,
    input  logic [COORD_W-1:0]                    disp_y,
    output logic [owner_width(NUM_PLAYERS)-1:0]   disp_owner
);

    localparam int OWNER_W = owner_width(NUM_PLAYERS);
    localparam int CELLS   = GRID_W * GRID_H;
    localparam int AW      = $clog2(CELLS);
    localparam int IW      = $clog2(NUM_PLAYERS);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_PLAYERS - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(CELLS - 1);

    function automatic logic in_grid(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
        return (32'(x) < 32'(GRID_W)) && (32'(y) < 32'(GRID_H));
    endfunction

    function automatic logic [AW-1:0] grid_addr(input logic [COORD_W-1:0] x,
                                                input logic [COORD_W-1:0] y);
        logic [31:0] a;
        a = cell_addr(32'(x), 32'(y), 32'(GRID_W));
        return a[AW-1:0];
    endfunction

    state_t               r_state;
    logic                 r_ready;
    logic                 r_done;
    logic [NUM_PLAYERS-1:0] r_alive;
    logic [NUM_PLAYERS-1:0] r_crashed;
    logic [NUM_PLAYERS-1:0] r_pend;
    logic [IW-1:0]        r_idx;
    logic                 r_phase;
    logic                 r_rd_pending;
    logic [AW-1:0]        r_clr_addr;
    logic                 r_clr_quiet;
    logic                 r_is_clear;
    logic                 r_disp_ok;
    logic [COORD_W-1:0]   r_hx [NUM_PLAYERS];
    logic [COORD_W-1:0]   r_hy [NUM_PLAYERS];

    logic [COORD_W-1:0]   w_cur_x;
    logic [COORD_W-1:0]   w_cur_y;
    logic                 w_cur_in;
    logic                 w_cur_live;
    logic [NUM_PLAYERS-1:0] w_headon;
    logic [NUM_PLAYERS-1:0] w_hit;
    logic                 w_en;
    logic                 w_we;
    logic [AW-1:0]        w_addr;
    logic [OWNER_W-1:0]   w_wdata;
    logic [OWNER_W-1:0]   w_rdata;
    logic [OWNER_W-1:0]   w_disp_rdata;

    assign w_cur_x    = r_hx[r_idx];
    assign w_cur_y    = r_hy[r_idx];
    assign w_cur_in   = in_grid(w_cur_x, w_cur_y);
    assign w_cur_live = r_alive[r_idx];

    always_comb begin
        w_headon = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            for (int j = i + 1; j < NUM_PLAYERS; j++) begin
                if (r_alive[i] && r_alive[j] && in_grid(r_hx[i], r_hy[i]) &&
                    r_hx[i] == r_hx[j] && r_hy[i] == r_hy[j]) begin
                    w_headon[i] = 1'b1;
                    w_headon[j] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_hit = '0;
        if (r_state == READ && r_phase && r_rd_pending && w_rdata != '0) begin
            w_hit[r_idx] = 1'b1;
        end
    end

    always_comb begin
        w_en    = 1'b0;
        w_we    = 1'b0;
        w_addr  = grid_addr(w_cur_x, w_cur_y);
        w_wdata = '0;
        case (r_state)
            CLEAR: begin
                w_en   = 1'b1;
                w_we   = 1'b1;
                w_addr = r_clr_addr;
            end
            READ: begin
                w_en = !r_phase && w_cur_live && w_cur_in;
            end
            WRITE: begin
                // A live, non-pending player is always in bounds: out-of-range heads set pending.
                w_en    = w_cur_live && !r_pend[r_idx];
                w_we    = w_en;
                w_wdata = OWNER_W'(r_idx) + OWNER_W'(1);
            end
            default: ;
        endcase
    end

    trail_ram #(
        .DEPTH(CELLS),
        .AW   (AW),
        .DW   (OWNER_W)
    ) u_ram (
        .clock    (clock),
        .i_a_en   (w_en),
        .i_a_we   (w_we),
        .i_a_addr (w_addr),
        .i_a_wdata(w_wdata),
        .o_a_rdata(w_rdata),
        .i_b_addr (grid_addr(disp_x, disp_y)),
        .o_b_rdata(w_disp_rdata)
    );

    assign disp_owner = r_disp_ok ? w_disp_rdata : '0;
    assign ready      = r_ready;
    assign done       = r_done;
    assign alive      = r_alive;
    assign crashed    = r_crashed;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= CLEAR;
            r_ready      <= 1'b0;
            r_done       <= 1'b0;
            r_alive      <= '1;
            r_crashed    <= '0;
            r_pend       <= '0;
            r_idx        <= '0;
            r_phase      <= 1'b0;
            r_rd_pending <= 1'b0;
            r_clr_addr   <= '0;
            r_clr_quiet  <= 1'b1;
            r_is_clear   <= 1'b1;
            r_disp_ok    <= 1'b0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                r_hx[i] <= '0;
                r_hy[i] <= '0;
            end
        end else begin
            r_done    <= 1'b0;
            r_disp_ok <= in_grid(disp_x, disp_y);
            case (r_state)
                IDLE: begin
                    if (clear_req) begin
                        r_state    <= CLEAR;
                        r_ready    <= 1'b0;
                        r_clr_addr <= '0;
                        r_is_clear <= 1'b1;
                    end else if (start && r_ready) begin
                        r_state    <= READ;
                        r_ready    <= 1'b0;
                        r_idx      <= '0;
                        r_phase    <= 1'b0;
                        r_pend     <= '0;
                        r_is_clear <= 1'b0;
                        for (int i = 0; i < NUM_PLAYERS; i++) begin
                            r_hx[i] <= head_x[i*COORD_W +: COORD_W];
                            r_hy[i] <= head_y[i*COORD_W +: COORD_W];
                        end
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                CLEAR: begin
                    r_clr_addr <= r_clr_addr + AW'(1);
                    if (r_clr_addr == LAST_ADDR) begin
                        r_state <= DONE;
                    end
                end
                READ: begin
                    if (!r_phase) begin
                        r_phase      <= 1'b1;
                        r_rd_pending <= w_en;
                        if (w_cur_live && !w_cur_in) begin
                            r_pend[r_idx] <= 1'b1;
                        end
                    end else begin
                        r_phase <= 1'b0;
                        if (r_idx == LAST_IDX) begin
                            r_pend  <= r_pend | w_hit | w_headon;
                            r_idx   <= '0;
                            r_state <= WRITE;
                        end else begin
                            r_pend <= r_pend | w_hit;
                            r_idx  <= r_idx + IW'(1);
                        end
                    end
                end
                WRITE: begin
                    if (r_idx == LAST_IDX) begin
                        r_idx   <= '0;
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    if (r_is_clear) begin
                        r_alive     <= '1;
                        r_crashed   <= '0;
                        r_done      <= !r_clr_quiet;
                        r_clr_quiet <= 1'b0;
                    end else begin
                        r_alive   <= r_alive & ~r_pend;
                        r_crashed <= r_pend & r_alive;
                        r_done    <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trail_engine.sv
// tb/tb_trail_engine.sv - directed scoreboard bench for trail_engine on a reduced 64x60 grid
module tb_trail_engine;

    localparam int N     = 2;
    localparam int GW    = 64;
    localparam int GH    = 60;
    localparam int CW    = 10;
    localparam int CELLS = GW * GH;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic            clear_req = 1'b0;
    logic            start = 1'b0;
    logic [N*CW-1:0] head_x = '0;
    logic [N*CW-1:0] head_y = '0;
    logic            ready;
    logic            done;
    logic [N-1:0]    alive;
    logic [N-1:0]    crashed;
    logic [CW-1:0]   disp_x = '0;
    logic [CW-1:0]   disp_y = '0;
    logic [1:0]      disp_owner;

    always #5 clock = ~clock;

    trail_engine #(
        .NUM_PLAYERS(N),
        .GRID_W     (GW),
        .GRID_H     (GH),
        .COORD_W    (CW)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear_req (clear_req),
        .start     (start),
        .head_x    (head_x),
        .head_y    (head_y),
        .ready     (ready),
        .done      (done),
        .alive     (alive),
        .crashed   (crashed),
        .disp_x    (disp_x),
        .disp_y    (disp_y),
        .disp_owner(disp_owner)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q [$];
    string       tag_q [$];

    task automatic expect_val(input string tag, input int v);
        tag_q.push_back(tag);
        exp_q.push_back(32'(v));
    endtask

    task automatic compare(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_empty: observed %0h expected nothing", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_err++;
                $error("FAIL %s: observed %0h expected %0h", t, obs, e);
            end
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic wait_ready(input int budget, output int cycles, output int dones);
        cycles = 0;
        dones  = 0;
        while (ready !== 1'b1 && cycles < budget) begin
            step();
            cycles++;
            if (done === 1'b1) dones++;
        end
    endtask

    task automatic set_heads(input int x0, input int y0, input int x1, input int y1);
        head_x = {CW'(x1), CW'(x0)};
        head_y = {CW'(y1), CW'(y0)};
    endtask

    task automatic run_tick(input string tag, input int x0, input int y0, input int x1,
                            input int y1, input int exp_crash, input int exp_alive);
        int c;
        int d;
        expect_val({tag, "_latency"}, 3 * N + 1);
        expect_val({tag, "_crashed"}, exp_crash);
        expect_val({tag, "_alive"}, exp_alive);
        expect_val({tag, "_ready_at_done"}, 0);
        expect_val({tag, "_ready_after"}, 1);
        wait_ready(50, c, d);
        set_heads(x0, y0, x1, y1);
        start = 1'b1;
        step();
        start = 1'b0;
        set_heads(7, 7, 7, 7);
        c = 0;
        while (done !== 1'b1 && c < 40) begin
            step();
            c++;
        end
        compare(32'(c));
        compare(32'(crashed));
        compare(32'(alive));
        compare(32'(ready));
        step();
        compare(32'(ready));
    endtask

    task automatic run_clear(input string tag, input logic with_start);
        int c;
        int d;
        expect_val({tag, "_latency"}, CELLS + 1);
        expect_val({tag, "_alive"}, 3);
        expect_val({tag, "_crashed"}, 0);
        wait_ready(50, c, d);
        set_heads(1, 1, 2, 2);
        clear_req = 1'b1;
        start     = with_start;
        step();
        clear_req = 1'b0;
        start     = 1'b0;
        c = 0;
        while (done !== 1'b1 && c < CELLS + 50) begin
            step();
            c++;
        end
        compare(32'(c));
        compare(32'(alive));
        compare(32'(crashed));
    endtask

    task automatic disp_check(input string tag, input int x, input int y, input int exp_owner);
        expect_val(tag, exp_owner);
        disp_x = CW'(x);
        disp_y = CW'(y);
        step();
        compare(32'(disp_owner));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        int d;
        step();
        step();
        expect_val("rst_ready", 0);
        expect_val("rst_done", 0);
        expect_val("rst_alive", 3);
        expect_val("rst_crashed", 0);
        expect_val("rst_disp_owner", 0);
        compare(32'(ready));
        compare(32'(done));
        compare(32'(alive));
        compare(32'(crashed));
        compare(32'(disp_owner));

        reset_n = 1'b1;
        expect_val("boot_ready_window", 1);
        expect_val("boot_done_pulses", 0);
        expect_val("boot_alive", 3);
        wait_ready(CELLS + 20, c, d);
        compare(32'(c >= CELLS && c <= CELLS + 3));
        compare(32'(d));
        compare(32'(alive));
        disp_check("boot_disp_origin", 0, 0, 0);
        disp_check("boot_disp_corner", GW - 1, GH - 1, 0);

        run_tick("free", 10, 10, 20, 20, 2'b00, 2'b11);
        disp_check("free_p0_cell", 10, 10, 1);
        disp_check("free_p1_cell", 20, 20, 2);

        run_tick("trail", 11, 10, 10, 10, 2'b10, 2'b01);
        disp_check("trail_cell_kept", 10, 10, 1);
        disp_check("trail_p0_cell", 11, 10, 1);

        run_tick("dead", 12, 10, 40, 40, 2'b00, 2'b01);
        disp_check("dead_p1_cell", 40, 40, 0);
        disp_check("dead_p0_cell", 12, 10, 1);

        run_clear("clr_start", 1'b1);
        disp_check("clr_start_wiped", 10, 10, 0);
        disp_check("clr_start_no_tick", 1, 1, 0);

        wait_ready(50, c, d);
        set_heads(30, 30, 31, 31);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 2 * N; i++) step();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        disp_check("abort_p0_cell", 30, 30, 0);
        disp_check("abort_p1_cell", 31, 31, 0);
        expect_val("abort_ready", 1);
        expect_val("abort_done_pulses", 0);
        expect_val("abort_alive", 3);
        wait_ready(CELLS + 20, c, d);
        compare(32'(ready));
        compare(32'(d));
        compare(32'(alive));

        run_tick("headon", 50, 50, 50, 50, 2'b11, 2'b00);
        disp_check("headon_cell", 50, 50, 0);

        run_clear("clr_plain", 1'b0);

        run_tick("wall", GW, 5, 6, 4, 2'b01, 2'b10);
        disp_check("wall_p1_cell", 6, 4, 2);
        disp_check("wall_alias_cell", 0, 6, 0);
        disp_check("disp_out_of_range", GW + 6, 3, 0);
        disp_check("wall_corner", GW - 1, GH - 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/trail_engine.md
# trail_engine

Sequential, parametrised successor to the combinational two-player trace updater. It holds the light-cycle trail grid in an internal dual-port RAM with per-cell owner IDs and supports N players. On each game tick it checks every live player's new head position for walls, trails and head-on collisions, then commits the survivors' heads. It sits between the game-tick controller, which supplies head positions, and the VGA renderer, which reads cell owners through an independent port.

## Interface
Parameters:
- NUM_PLAYERS, 2: number of players (2..8).
- GRID_W, 200: grid columns (x range 0..GRID_W-1).
- GRID_H, 150: grid rows (y range 0..GRID_H-1).
- COORD_W, 10: width of every x/y coordinate.

Ports:
- clock, input, 1: single clock. All logic is on the rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- clear_req, input, 1: request a full grid wipe and revive all players. Sampled only in IDLE.
- start, input, 1: tick request. Accepted only when start && ready.
- head_x, input, NUM_PLAYERS×COORD_W: new head x per player. Sampled at accept.
- head_y, input, NUM_PLAYERS×COORD_W: new head y per player. Sampled at accept.
- ready, output, 1: high only in IDLE.
- done, output, 1: one-cycle pulse when a tick or a clear completes.
- alive, output, NUM_PLAYERS: sticky per-player alive flags.
- crashed, output, NUM_PLAYERS: players that died on the last tick. Valid from done until the next accept.
- disp_x, input, COORD_W: renderer read x.
- disp_y, input, COORD_W: renderer read y.
- disp_owner, output, OWNER_W: owner of cell (disp_x, disp_y). 0 means empty, k means player k-1. Registered.

## Operation
- Each cell stores OWNER_W = $clog2(NUM_PLAYERS+1) bits.
- FSM states and transitions:
  - IDLE → CLEAR on clear_req.
  - IDLE → READ on start.
  - CLEAR → DONE.
  - READ → WRITE.
  - WRITE → DONE.
  - DONE → IDLE.
- CLEAR:
  - Writes 0 to every cell, one cell per cycle, linear address y*GRID_W+x.
  - Then sets alive to all ones and crashed to 0.
- READ: for each player i (0..N-1) in order:
  - If alive[i] and the head is in bounds, issue a RAM read of the head cell.
  - The data returns the next cycle. Mark a pending crash if the cell is non-zero.
  - Out of bounds (x ≥ GRID_W or y ≥ GRID_H) is a pending crash with no RAM access.
  - Dead players are skipped, but their slot is still consumed.
- Head-on rule: after READ, any two live players with identical in-bounds heads both get a pending crash.
- WRITE: for each player i in order:
  - If alive and not pending-crash, write owner i+1 to its head cell.
  - All checks finish before any write, so the result does not depend on player order.
- DONE:
  - alive &= ~pending.
  - crashed = pending & previous alive.
  - done pulses.
- Signals ignored outside IDLE: start, clear_req, head_x and head_y. If start and clear_req are both high in IDLE, clear wins and the start is dropped.
- Display port: disp_owner = RAM[disp_y*GRID_W+disp_x], registered. An out-of-range disp coordinate returns 0. Values during CLEAR may be stale.

## Timing
- A tick takes 3·NUM_PLAYERS + 1 cycles from accept to done, independent of the alive pattern:
  - READ: 2N cycles.
  - WRITE: N cycles.
  - DONE: 1 cycle.
- ready falls the cycle after accept and rises the cycle after done.
- A clear takes GRID_W·GRID_H + 1 cycles from accept to done.
- disp_owner latency is 1 cycle. A same-cycle engine write to that cell returns the old value.
- Reset values: ready=0, done=0, alive=all ones, crashed=0, disp_owner=0.
- Leaving reset:
  - The FSM enters CLEAR automatically (grid contents are undefined after power-up).
  - ready rises after the first clear completes.
  - That reset-triggered clear does not pulse done.
- reset_n asserted mid-tick or mid-clear aborts immediately. No further writes are issued, and the engine restarts with the CLEAR described above.

## Structure
- Package trail_pkg holds:
  - the state enum {IDLE, CLEAR, READ, WRITE, DONE};
  - the default GRID_W/GRID_H constants;
  - the owner_t width function;
  - the address-compute function y*GRID_W+x.
- Sub-module trail_ram: a simple dual-port RAM with one synchronous read/write port for the engine and one synchronous read port for display. It must be written to infer block RAM, with no reset on its contents.
- The FSM, player index counter, clear address counter and pending mask live in trail_engine.

## Test plan
- Reset release: CLEAR runs for GRID_W·GRID_H cycles, then ready=1, alive=2'b11, and disp_owner=0 at (0,0) and (199,149).
- Free move, N=2, heads (10,10) and (20,20): done arrives exactly 7 cycles after accept, crashed=0, disp_owner(10,10)=1 and disp_owner(20,20)=2.
- Trail hit: P0's cell (10,10) is already owned, and P1 moves to (10,10). Result: crashed=2'b10, alive=2'b01, and (10,10) still reads owner 1.
- Head-on and wall: both heads at (50,50) gives crashed=2'b11 and cell (50,50) stays 0. A separate tick with P0 at x=200 gives crashed[0]=1 and no RAM write.
- Dead player: with alive=2'b01, P1's head lands on an empty cell. Its cell stays 0, the tick still takes 7 cycles, and crashed[1]=0.
- Abort and priority:
  - reset_n low during WRITE: no owner write appears, and a full CLEAR follows.
  - start and clear_req together in IDLE: only the clear runs (done after GRID_W·GRID_H+1 cycles), and alive returns to all ones.
